ibuf_filter: RTL and testbench
==============================

# ibuf_filter

Synchronizing, glitch-filtering input buffer for a bidirectional pad: the receive-side counterpart of the registered tri-state output buffer. It samples the pad level through a flop synchronizer, rejects pulses shorter than a programmable number of cycles, and presents a clean registered level with one-cycle rise/fall strobes. Each accepted edge is also offered as a timestamped event on a valid/ready port, with a sticky overrun flag for dropped events. It sits between the pad's inout net and core logic that needs clean edges.

## Interface
- SYNC_STAGES, 2: synchronizer depth; must be ≥ 2
- FILTER_LEN, 4: consecutive stable cycles needed to accept a new level; must be ≥ 1
- TS_W, 16: timestamp width
- clk  input  1  clock; all logic on its rising edge
- rst  input  1  synchronous, active-low reset
- ie  input  1  input enable; 0 freezes `y` and suppresses events
- z  input  1  raw pad level, asynchronous to `clk`
- y  output  1  filtered level, registered
- rise  output  1  one-cycle strobe when `y` goes 0→1
- fall  output  1  one-cycle strobe when `y` goes 1→0
- evt_valid  output  1  event register holds an event
- evt_ready  input  1  consumer accepts the event
- evt_level  output  1  new level of `y` for the held event
- evt_time  output  TS_W  timestamp of the held event
- overrun  output  1  sticky; an event was dropped
- clr_overrun  input  1  clears `overrun`

## Operation
- Reset (rst=0 at a clock edge) zeroes every register: all sync stages, the filter counter, `y`, `rise`, `fall`, `evt_valid`, `evt_level`, `evt_time`, `overrun`, and the timestamp counter. Reset asserted mid-operation discards any pending count or event.
- Synchronizer: `z` shifts through SYNC_STAGES flops. The last stage is `s`.
- Timestamp `ts`: a free-running TS_W-bit counter that increments every non-reset cycle regardless of `ie`. It wraps from 2^TS_W−1 to 0.
- Filter counter `cnt` (width clog2(FILTER_LEN), minimum 1 bit):
  - ie=0: `cnt`←0, `y` holds, no strobes, no events.
  - ie=1 and s==y: `cnt`←0.
  - ie=1, s≠y, and cnt<FILTER_LEN−1: `cnt`←cnt+1.
  - ie=1, s≠y, and cnt==FILTER_LEN−1: `y`←s and `cnt`←0. The matching `rise` or `fall` is 1 for exactly this cycle; both are 0 otherwise. This is an "accepted edge".
- A mismatch run broken before FILTER_LEN cycles is rejected: the glitch produces no output change.
- Event register (single entry):
  - Accepted edge and (evt_valid=0 or evt_ready=1): load evt_level←new y, evt_time←ts (value before this cycle's increment), evt_valid←1.
  - Accepted edge with evt_valid=1 and evt_ready=0: the held event is unchanged, the new event is dropped, and overrun←1.
  - No accepted edge, evt_valid=1 and evt_ready=1: evt_valid←0.
  - `evt_level` and `evt_time` are stable while evt_valid=1 and evt_ready=0.
- Overrun: clr_overrun=1 clears `overrun`. If a drop happens in the same cycle as clr_overrun, set wins.

## Timing
- Counting the first edge that samples the new `z` as edge 1, `s` changes at edge SYNC_STAGES and `y` changes at edge SYNC_STAGES+FILTER_LEN. With defaults, that is edge 6.
- `rise`/`fall` and `evt_valid` assert together with the `y` change. The event is consumable in that same cycle.
- Minimum `z` pulse width that always propagates: FILTER_LEN cycles. Narrower pulses are always rejected.
- Maximum event throughput: one per FILTER_LEN cycles. This is sustainable with evt_ready held at 1.

## Test plan
- Reset: hold rst=0 for 3 cycles with z=1, then release → y=0, evt_valid=0, overrun=0 at release. y=1 appears 6 edges after release (defaults).
- Clean edge: z 0→1 held, ts=0x0010 at the accepting edge → y=1 at edge 6, rise=1 for one cycle, evt_valid=1, evt_level=1, evt_time=0x0010. evt_ready=1 for one cycle → evt_valid=0 next cycle.
- Glitch rejection: z=1 for 3 cycles then back to 0 → y stays 0, no strobes, evt_valid stays 0. The same test with 4 cycles → y=1 pulse, with rise and then fall strobes.
- Backpressure/overrun: evt_ready=0; z rises, then falls 10 cycles later → event holds level=1, second event dropped, overrun=1. clr_overrun=1 alone → overrun=0. clr_overrun in the same cycle as a drop → overrun=1.
- Input enable: ie=0, toggle z freely → y frozen, no strobes or events. ie→1 with s≠y → y updates FILTER_LEN cycles later. Dropping ie at cnt=2 → no update, cnt restarts.
- Simultaneous hand-off and wrap: evt_valid=1 and evt_ready=1 in the same cycle as an accepted edge → new event loaded and evt_valid stays 1. With TS_W=4, an edge accepted at ts=15 gives evt_time=15, and the next cycle ts=0.

Source files
------------

// File: rtl/ibuf_filter.sv
// Receive-side pad buffer: synchronizes the raw pad level, rejects short glitches,
// and reports each accepted edge as a registered level, strobes and a timestamped event.
module ibuf_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TS_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ie,
  input  logic            z,
  output logic            y,
  output logic            rise,
  output logic            fall,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_level,
  output logic [TS_W-1:0] evt_time,
  output logic            overrun,
  input  logic            clr_overrun
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [TS_W-1:0]        ts_r;
  logic                   y_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   evt_valid_r;
  logic                   evt_level_r;
  logic [TS_W-1:0]        evt_time_r;
  logic                   overrun_r;

  logic s_s;
  logic accept_s;
  logic load_s;
  logic drop_s;

  // Decode the accepted-edge condition and what it does to the single-entry event slot.
  always_comb begin
    s_s      = sync_r[SYNC_STAGES-1];
    accept_s = ie && (s_s != y_r) && (cnt_r == CNT_MAX);
    load_s   = accept_s && (!evt_valid_r || evt_ready);
    drop_s   = accept_s && evt_valid_r && !evt_ready;
  end

  // Pad-level synchronizer chain and free-running timestamp.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      ts_r   <= {TS_W{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], z};
      ts_r   <= ts_r + TS_W'(1);
    end
  end

  // Glitch filter: a level is accepted only after FILTER_LEN consecutive enabled mismatches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      y_r    <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (!ie || (s_s == y_r)) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
        cnt_r  <= {CNT_W{1'b0}};
        y_r    <= s_s;
        rise_r <= s_s;
        fall_r <= !s_s;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Event slot with sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_valid_r <= 1'b0;
      evt_level_r <= 1'b0;
      evt_time_r  <= {TS_W{1'b0}};
      overrun_r   <= 1'b0;
    end else begin
      if (load_s) begin
        evt_valid_r <= 1'b1;
        evt_level_r <= s_s;
        evt_time_r  <= ts_r;
      end else if (evt_valid_r && evt_ready && !accept_s) begin
        evt_valid_r <= 1'b0;
      end else begin
        evt_valid_r <= evt_valid_r;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign y         = y_r;
  assign rise      = rise_r;
  assign fall      = fall_r;
  assign evt_valid = evt_valid_r;
  assign evt_level = evt_level_r;
  assign evt_time  = evt_time_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_ibuf_filter.sv
// Bench for ibuf_filter: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a window-based model of the filter and event slot.
module tb_ibuf_filter;
  localparam int SS = 2;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst, ie, z, evt_ready, clr_overrun;
  logic y, rise, fall, evt_valid, evt_level, overrun;
  logic [15:0] evt_time;
  logic y4, rise4, fall4, evt_valid4, evt_level4, overrun4;
  logic [3:0] evt_time4;

  int n_cmp = 0;
  int n_bad = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  always #5 clk = ~clk;

  ibuf_filter #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .ie(ie), .z(z), .y(y), .rise(rise), .fall(fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_level(evt_level),
    .evt_time(evt_time), .overrun(overrun), .clr_overrun(clr_overrun));

  ibuf_filter #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .TS_W(4)) dut4 (
    .clk(clk), .rst(rst), .ie(ie), .z(z), .y(y4), .rise(rise4), .fall(fall4),
    .evt_valid(evt_valid4), .evt_ready(evt_ready), .evt_level(evt_level4),
    .evt_time(evt_time4), .overrun(overrun4), .clr_overrun(clr_overrun));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pad history delayed by the synchronizer, a run window of enabled
  // mismatches, and a single-entry event slot; stamps count cycles since reset.
  logic zq[$];
  bit   win[$];
  logic my, mr, mf, mv, ml, mo;
  int   mt, tsc;

  always @(posedge clk) begin
    logic s_pre, acc, drop;
    if (!rst) begin
      zq.delete();
      for (int i = 0; i < SS; i++) zq.push_back(1'b0);
      win.delete();
      my = 1'b0; mr = 1'b0; mf = 1'b0; mv = 1'b0; ml = 1'b0; mo = 1'b0;
      mt = 0; tsc = 0;
    end else begin
      s_pre = zq[0];
      zq.pop_front();
      zq.push_back(z);
      acc = 1'b0; drop = 1'b0; mr = 1'b0; mf = 1'b0;
      if (ie && (s_pre !== my)) begin
        win.push_back(1'b1);
        if (win.size() == FL) acc = 1'b1;
      end else begin
        win.delete();
      end
      if (acc) begin
        my = s_pre; mr = s_pre; mf = !s_pre;
        win.delete();
        if (!mv || evt_ready) begin
          mv = 1'b1; ml = s_pre; mt = tsc;
        end else begin
          drop = 1'b1;
        end
      end else if (mv && evt_ready) begin
        mv = 1'b0;
      end
      if (drop) mo = 1'b1;
      else if (clr_overrun) mo = 1'b0;
      tsc++;
    end
    #1;
    chk("y", y, my);
    chk("rise", rise, mr);
    chk("fall", fall, mf);
    chk("evt_valid", evt_valid, mv);
    chk("overrun", overrun, mo);
    chk("evt_valid4", evt_valid4, mv);
    if (mv) begin
      chk("evt_level", evt_level, ml);
      chk("evt_time", evt_time, 32'(mt % 65536));
      chk("evt_time4", evt_time4, 32'(mt % 16));
    end
  end

  // Strobe tallies used by the directed glitch and enable scenarios.
  always @(posedge clk) begin
    #1;
    if (rise === 1'b1) rise_cnt++;
    if (fall === 1'b1) fall_cnt++;
  end

  initial begin
    int r0, f0, hold;
    rst = 1'b0; z = 1'b1; ie = 1'b1; evt_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rel_y", y, 0);
    chk("rel_evt_valid", evt_valid, 0);
    chk("rel_overrun", overrun, 0);
    repeat (5) @(negedge clk);
    chk("edge5_y", y, 0);
    @(negedge clk);
    chk("edge6_y", y, 1);
    chk("edge6_rise", rise, 1);
    chk("edge6_evt_valid", evt_valid, 1);
    chk("edge6_evt_level", evt_level, 1);
    chk("edge6_evt_time", evt_time, 5);
    chk("edge6_evt_time4", evt_time4, 5);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("consume_valid", evt_valid, 0);
    chk("rise_one_cycle", rise, 0);

    // glitch rejection (3 cycles) versus propagation (4 cycles)
    z = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_glitch_y", y, 0);
    r0 = rise_cnt; f0 = fall_cnt;
    z = 1'b1; repeat (3) @(negedge clk);
    z = 1'b0; repeat (10) @(negedge clk);
    chk("glitch3_rise", rise_cnt, r0);
    chk("glitch3_y", y, 0);
    chk("glitch3_evt", evt_valid, 0);
    z = 1'b1; repeat (4) @(negedge clk);
    z = 1'b0; repeat (10) @(negedge clk);
    chk("pulse4_rise", rise_cnt, r0 + 1);
    chk("pulse4_fall", fall_cnt, f0 + 1);
    chk("pulse4_y", y, 0);

    // backpressure, overrun, clear, clear-versus-drop
    evt_ready = 1'b0;
    z = 1'b1; repeat (10) @(negedge clk);
    z = 1'b0; repeat (10) @(negedge clk);
    chk("bp_valid", evt_valid, 1);
    chk("bp_level", evt_level, 1);
    chk("bp_overrun", overrun, 1);
    clr_overrun = 1'b1; @(negedge clk); clr_overrun = 1'b0;
    chk("clr_overrun", overrun, 0);
    z = 1'b1; repeat (5) @(negedge clk);
    clr_overrun = 1'b1; @(negedge clk); clr_overrun = 1'b0;
    chk("clr_vs_drop", overrun, 1);
    chk("clr_vs_drop_y", y, 1);

    // input enable freeze, resume, and interrupted count
    ie = 1'b0; evt_ready = 1'b1;
    r0 = rise_cnt; f0 = fall_cnt;
    repeat (20) begin z = 1'($urandom); @(negedge clk); end
    chk("ie0_rise", rise_cnt, r0);
    chk("ie0_fall", fall_cnt, f0);
    chk("ie0_y", y, 1);
    chk("ie0_evt", evt_valid, 0);
    z = 1'b0; repeat (4) @(negedge clk);
    ie = 1'b1; repeat (3) @(negedge clk);
    chk("ie1_wait_y", y, 1);
    @(negedge clk);
    chk("ie1_update_y", y, 0);
    z = 1'b1; repeat (4) @(negedge clk);
    ie = 1'b0; @(negedge clk);
    ie = 1'b1; repeat (3) @(negedge clk);
    chk("ie_restart_y", y, 0);
    @(negedge clk);
    chk("ie_restart_done", y, 1);

    // hand-off: held event consumed in the same cycle a new edge is accepted
    evt_ready = 1'b0;
    z = 1'b0; repeat (5) @(negedge clk);
    chk("handoff_pre_valid", evt_valid, 1);
    evt_ready = 1'b1; @(negedge clk);
    evt_ready = 1'b0;
    chk("handoff_valid", evt_valid, 1);
    chk("handoff_level", evt_level, 0);

    // randomized phase
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        z = 1'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      ie = ($urandom_range(0, 15) != 0);
      evt_ready = 1'($urandom);
      clr_overrun = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
